// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the control-state type. The instruction decoder imports this
// package too, so the encodings have a single source.
package mdu_pkg;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  // md_op encodings; 3'd6 and 3'd7 are reserved no-ops.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // True for the four multi-cycle arithmetic operations.
  function automatic logic is_muldiv(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU hold busy for a fixed latency and write HI/LO on the
// edge busy falls; MTHI/MTLO write immediately when the unit is idle.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               accept;
  logic               done;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;

  // A new multiply/divide is only taken while idle; anything else in BUSY is dropped.
  assign accept = start && (state_q == ST_IDLE) && is_muldiv(md_op);
  assign done   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  // State and counter register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load the latency on accept, count down while busy.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = is_mul(md_op) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at accept; results depend only on these copies.
  always_ff @(posedge clk) begin
    // NOTE: operand copies carry no reset; they are always rewritten before use.
    if (accept) begin
      op_q <= md_op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Behavioural arithmetic on the latched operands.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Division results; the one signed overflow case is pinned explicitly.
  always_comb begin
    quot_u = a_q / b_q;
    rem_u  = a_q % b_q;
    if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'h0;
    end else begin
      quot_s = 32'($signed(a_q) / $signed(b_q));
      rem_s  = 32'($signed(a_q) % $signed(b_q));
    end
  end

  // Output logic: HI/LO next values from MTHI/MTLO in idle or a completing op.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (start && (state_q == ST_IDLE)) begin
      if (md_op == MD_MTHI) hi_d = a;
      if (md_op == MD_MTLO) lo_d = a;
    end
    if (done) begin
      unique case (op_q)
        MD_MULT:  {hi_d, lo_d} = prod_s;
        MD_MULTU: {hi_d, lo_d} = prod_u;
        MD_DIV:   if (b_q != 32'h0) begin hi_d = rem_s; lo_d = quot_s; end
        MD_DIVU:  if (b_q != 32'h0) begin hi_d = rem_u; lo_d = quot_u; end
        default:  ;
      endcase
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner
// sequences, and random operations against an arithmetic reference model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mhi, mlo;  // model HI/LO

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  function automatic int model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                               inout logic [31:0] h, inout logic [31:0] l);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (op)
      3'd0: begin sq = sx * sy; {h, l} = sq; return 5; end
      3'd1: begin up = ux * uy; {h, l} = up; return 5; end
      3'd2: begin
        if (y != 0) begin sq = sx / sy; sr = sx % sy; l = sq[31:0]; h = sr[31:0]; end
        return 10;
      end
      3'd3: begin
        if (y != 0) begin up = ux / uy; l = up[31:0]; up = ux % uy; h = up[31:0]; end
        return 10;
      end
      3'd4: begin h = x; return 0; end
      3'd5: begin l = x; return 0; end
      default: return 0;
    endcase
  endfunction

  // Called at a negedge: issue one op, count busy cycles (bounded), verify
  // HI/LO held while busy, then verify final HI/LO. Returns at the first
  // idle negedge so the next call starts in the cycle busy falls.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   n = 0;
    logic held = 1'b1;
    logic [31:0] pre_hi = hi;
    logic [31:0] pre_lo = lo;
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 50) begin
      if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
      a = $urandom; b = $urandom;  // operand changes mid-op must not matter
      n++;
      @(negedge clk);
    end
    check({name, ".cycles"}, 64'(n), 64'(exp_cyc));
    check({name, ".held"}, {63'b0, held}, 64'd1);
    check({name, ".hi"}, {32'b0, hi}, {32'b0, exp_hi});
    check({name, ".lo"}, {32'b0, lo}, {32'b0, exp_lo});
    mhi = exp_hi;
    mlo = exp_lo;
  endtask

  vec_t vecs[14];

  initial begin
    logic ok;
    int   n;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{3'd3, 32'h7,         32'h2,         32'h1,         32'h3,         10};
    vecs[4]  = '{3'd4, 32'h11,        32'h0,         32'h11,        32'h3,         0};
    vecs[5]  = '{3'd5, 32'h22,        32'h0,         32'h11,        32'h22,        0};
    vecs[6]  = '{3'd2, 32'h5,         32'h0,         32'h11,        32'h22,        10};
    vecs[7]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10};
    vecs[8]  = '{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 10};
    vecs[9]  = '{3'd6, 32'hDEAD_BEEF, 32'h1,         32'h1,         32'hFFFF_FFFD, 0};
    vecs[10] = '{3'd3, 32'h5,         32'h0,         32'h1,         32'hFFFF_FFFD, 10};
    vecs[11] = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 5};
    vecs[12] = '{3'd7, 32'h1234_5678, 32'h9,         32'hC000_0000, 32'h8000_0000, 0};
    vecs[13] = '{3'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 10};

    reset = 1'b1; start = 1'b0; md_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", {63'b0, busy}, 64'd0);
    check("reset.hi", {32'b0, hi}, 64'd0);
    check("reset.lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table, issued back-to-back (each start lands as busy falls).
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_cyc, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTLO while MULT busy is ignored; MTLO in the cycle busy falls lands.
    start = 1'b1; md_op = 3'd0; a = 32'hFFFF_FFFE; b = 32'h3;
    @(negedge clk);                       // busy cycle 1
    start = 1'b0;
    @(negedge clk);                       // busy cycle 2
    start = 1'b1; md_op = 3'd5; a = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    check("mtlo_busy.cycles", 64'(n), 64'd3);
    check("mtlo_busy.hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("mtlo_busy.lo", {32'b0, lo}, 64'hFFFF_FFFA);
    run_op("mtlo_after", 3'd5, 32'hABCD, 32'h0, 0, 32'hFFFF_FFFF, 32'h0000_ABCD);

    // Reset at DIV busy cycle 4 discards the result and clears HI/LO.
    start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);            // now in busy cycle 4
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid.busy", {63'b0, busy}, 64'd0);
    check("rst_mid.hi", {32'b0, hi}, 64'd0);
    check("rst_mid.lo", {32'b0, lo}, 64'd0);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) ok = 1'b0;
    end
    check("rst_mid.stay0", {63'b0, ok}, 64'd1);

    // Reset beats a simultaneous start.
    reset = 1'b1; start = 1'b1; md_op = 3'd4; a = 32'h5555;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio.busy", {63'b0, busy}, 64'd0);
    check("rst_prio.hi", {32'b0, hi}, 64'd0);
    mhi = 32'h0; mlo = 32'h0;

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] x, y, eh, el;
      int          cyc;
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 20));
        2:       y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      eh  = mhi;
      el  = mlo;
      cyc = model(op, x, y, eh, el);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, x, y, cyc, eh, el);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
